// File: rtl/fifo_downsizer.sv
// Width downsizer between a first-word-fall-through FIFO and a ready/valid stream.
// Each FIFO word is sent LSB slice first; o_last marks the end of every BURST_WORDS-word burst.
module fifo_downsizer #(
  parameter int IN_WIDTH    = 512,
  parameter int OUT_WIDTH   = 64,
  parameter int BURST_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_fifo_empty,
  input  logic [IN_WIDTH-1:0]  i_fifo_data,
  output logic                 o_fifo_ren,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_last,
  output logic                 o_busy
);

  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W  = $clog2(RATIO);
  localparam int WCNT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_r;
  logic [IN_WIDTH-1:0]  hold_r;
  logic [CNT_W-1:0]     beat_cnt_r;
  logic [WCNT_W-1:0]    word_cnt_r;

  logic accept_s;
  logic final_s;
  logic ren_s;
  logic last_beat_s;
  logic burst_end_s;

  assign accept_s    = (state_r == SEND) && i_ready;
  assign last_beat_s = (beat_cnt_r == CNT_W'(RATIO - 1));
  assign final_s     = accept_s && last_beat_s;
  assign burst_end_s = (word_cnt_r == WCNT_W'(BURST_WORDS - 1));
  // Reset gating keeps the pop strobe quiet while the FSM is forced to IDLE.
  assign ren_s       = i_rst_n && !i_fifo_empty && ((state_r == IDLE) || final_s);

  // Word hold register, beat counter and IDLE/SEND state; a pop reloads with no bubble.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= IDLE;
      hold_r     <= '0;
      beat_cnt_r <= '0;
    end else if (ren_s) begin
      state_r    <= SEND;
      hold_r     <= i_fifo_data;
      beat_cnt_r <= '0;
    end else if (accept_s) begin
      beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      state_r    <= final_s ? IDLE : SEND;
    end
  end

  // Words-in-burst counter; survives idle gaps so only the burst length ends a burst.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_cnt_r <= '0;
    end else if (final_s) begin
      word_cnt_r <= burst_end_s ? '0 : word_cnt_r + WCNT_W'(1);
    end
  end

  assign o_fifo_ren = ren_s;
  assign o_valid    = (state_r == SEND);
  assign o_data     = hold_r[int'(beat_cnt_r) * OUT_WIDTH +: OUT_WIDTH];
  assign o_last     = (state_r == SEND) && last_beat_s && burst_end_s;
  assign o_busy     = (state_r == SEND) || (word_cnt_r != '0);

endmodule

// File: tb/tb_fifo_downsizer.sv
// Bench for fifo_downsizer (32 -> 8 bits, 2-word bursts): FIFO model plus expected-beat queue.
module tb_fifo_downsizer;
  localparam int IW = 32;
  localparam int OW = 8;
  localparam int BW = 2;
  localparam int R  = IW / OW;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_fifo_empty;
  logic [IW-1:0] i_fifo_data;
  logic          o_fifo_ren;
  logic          o_valid;
  logic          i_ready;
  logic [OW-1:0] o_data;
  logic          o_last;
  logic          o_busy;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
    logic          eow;
  } beat_t;

  beat_t         exp_q[$];
  logic [IW-1:0] fifo_q[$];
  int            pushed = 0;
  int            sent   = 0;
  int            total  = 0;
  int            bad    = 0;
  int            n;

  fifo_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .BURST_WORDS(BW)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data),
    .o_fifo_ren(o_fifo_ren), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_last(o_last), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  // Queue a FIFO word and derive its beats: LSB first, last on every BW-th word's final beat.
  task automatic push(input logic [IW-1:0] w);
    fifo_q.push_back(w);
    for (int b = 0; b < R; b++) begin
      beat_t t;
      t.data = w[b*OW +: OW];
      t.eow  = (b == R - 1);
      t.last = t.eow && ((pushed % BW) == BW - 1);
      exp_q.push_back(t);
    end
    pushed++;
    drive_fifo();
  endtask

  // One clock: check outputs on the falling edge, then advance the models after the rising edge.
  task automatic step(input logic rdy_next);
    int   pending;
    logic exp_ren;
    @(negedge clk);
    pending = exp_q.size() - R * fifo_q.size();
    exp_ren = (fifo_q.size() > 0) && ((pending == 0) || (i_ready && pending == 1));
    chk("ren", 32'(o_fifo_ren), 32'(exp_ren));
    chk("valid", 32'(o_valid), 32'(pending > 0));
    chk("busy", 32'(o_busy), 32'((pending > 0) || ((sent % BW) != 0)));
    if (pending > 0) begin
      chk("data", 32'(o_data), 32'(exp_q[0].data));
      chk("last", 32'(o_last), 32'(exp_q[0].last));
      if (i_ready) begin
        if (exp_q[0].eow) sent++;
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (exp_ren) void'(fifo_q.pop_front());
    drive_fifo();
    i_ready = rdy_next;
  endtask

  task automatic drain(input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < budget) begin
      step(1'b1);
      cycles++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_ready      = 1'b1;
    i_fifo_empty = 1'b0;
    i_fifo_data  = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    chk("rst_ren", 32'(o_fifo_ren), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    @(posedge clk);
    #1;
    drive_fifo();
    i_rst_n = 1'b1;

    // Empty FIFO: nothing popped, nothing sent.
    repeat (5) step(1'b1);

    // Single word then an idle gap inside the burst.
    push(32'h44332211);
    drain(20, n);
    chk("one_word_cycles", 32'(n), 32'd5);
    repeat (10) step(1'b1);
    push(32'hC3C2C1C0);
    drain(20, n);
    chk("gap_word_cycles", 32'(n), 32'd5);
    step(1'b1);

    // Back-to-back words: the reload must not insert a bubble.
    push(32'hA3A2A1A0);
    push(32'hB3B2B1B0);
    drain(30, n);
    chk("b2b_cycles", 32'(n), 32'd9);
    step(1'b1);

    // Backpressure for three cycles on the second beat with another word waiting.
    push(32'h44332211);
    step(1'b1);
    push(32'h88776655);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    drain(30, n);
    chk("stall_tail_cycles", 32'(n), 32'd7);
    step(1'b1);

    // Reset while the second word of a burst is on its third beat.
    push(32'hE3E2E1E0);
    push(32'hF3F2F1F0);
    n = 0;
    while (exp_q.size() > 2 && n < 30) begin
      step(1'b1);
      n++;
    end
    chk("pre_rst_pos", 32'(exp_q.size()), 32'd2);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_data", 32'(o_data), 32'd0);
    exp_q.delete();
    fifo_q.delete();
    pushed = 0;
    sent   = 0;
    drive_fifo();
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    push(32'h13121110);
    push(32'h17161514);
    drain(30, n);
    chk("post_rst_cycles", 32'(n), 32'd9);
    step(1'b1);

    // Random traffic: random words, gaps and backpressure.
    repeat (300) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0) push($urandom);
      step($urandom_range(0, 3) != 0);
    end
    drain(400, n);
    step(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
